// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_t : miss-tracking FSM encoding
//   REG_ZERO   : architectural zero register, never a real dependency
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IF_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter for performance statistics.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears to 0)
//   inc        : count one event this cycle
//   count      : current value; sticks at all-ones instead of wrapping
module hz_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Decides each cycle whether PC, IF/ID, ID/EX, EX/MEM, MEM/WB load, hold or
// take a bubble; tracks outstanding I/D cache misses and redirects that
// land while a fetch is still outstanding.
//
// state    | meaning
// ---------+---------------------------------------------
// RUN      | no miss outstanding
// IF_WAIT  | I-cache miss outstanding, front end stalled
// MEM_WAIT | D-cache/store-buffer miss, whole pipe frozen
//
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   id_rs1/2, id_use_rs1/2  : ID instruction sources
//   ex_rd, ex_load          : EX destination, EX is a load
//   ex_redirect             : control transfer resolved in EX
//   imem_miss, dmem_miss    : cache not ready this cycle
//   *_hold, *_bubble        : stage register controls (combinational)
//   stall_cycles, loaduse_bubbles, flush_count : saturating counters
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_redirect,
  input  logic             imem_miss,
  input  logic             dmem_miss,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_bubble,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] loaduse_bubbles,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_t state_q, state_d;
  logic      flush_pending_q, flush_pending_d;
  logic      lu, mem_stall, fetch_stall;
  logic      inc_stall, inc_lu, inc_flush;

  always_comb begin
    lu = ex_load && (ex_rd != REG_ZERO) &&
         ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    mem_stall   = (state_q == MEM_WAIT) || dmem_miss;
    fetch_stall = (state_q == IF_WAIT) || imem_miss;

    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    ifid_bubble  = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    inc_lu       = 1'b0;
    inc_flush    = 1'b0;

    if (!reset) begin
      if (mem_stall) begin
        // A frozen EX also swallows any redirect; it is re-presented later.
        pc_hold      = 1'b1;
        ifid_hold    = 1'b1;
        idex_hold    = 1'b1;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
      end else if (ex_redirect) begin
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
        inc_flush   = 1'b1;
      end else if (lu) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
        inc_lu      = 1'b1;
      end else if (fetch_stall || flush_pending_q) begin
        // A pending flush alone only drops the returned wrong-path word.
        pc_hold     = fetch_stall;
        ifid_bubble = 1'b1;
      end
    end

    inc_stall = pc_hold | ifid_hold | idex_hold | exmem_hold |
                ifid_bubble | idex_bubble | memwb_bubble;
  end

  // D-side miss always wins; otherwise the I-side miss decides.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dmem_miss)      state_d = MEM_WAIT;
        else if (imem_miss) state_d = IF_WAIT;
      end
      MEM_WAIT: begin
        if (!dmem_miss) state_d = imem_miss ? IF_WAIT : RUN;
      end
      IF_WAIT: begin
        if (dmem_miss)      state_d = MEM_WAIT;
        else if (!imem_miss) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Clearing happens on the cycle the fetch returns with the pipe moving,
  // which is exactly the cycle that bubbles the wrong-path word. A redirect
  // arriving in that same cycle bubbles it itself, so nothing stays pending.
  always_comb begin
    flush_pending_d = flush_pending_q;
    if (!mem_stall && !imem_miss) begin
      flush_pending_d = 1'b0;
    end else if (!mem_stall && ex_redirect && fetch_stall) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  hz_sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk(clk), .reset(reset), .inc(inc_stall), .count(stall_cycles)
  );

  hz_sat_counter #(.W(CNT_W)) u_cnt_lu (
    .clk(clk), .reset(reset), .inc(inc_lu), .count(loaduse_bubbles)
  );

  hz_sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk(clk), .reset(reset), .inc(inc_flush), .count(flush_count)
  );

endmodule
